blc_line_ctrl: RTL and testbench
================================

BLC_LINE_CTRL -- requirements
Module: blc_line_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DATA_WIDTH, 8, pixel width
- BPS_L, 1, first left-black pixel index
- BPN_L, 128, left-black count
- READ_PIXEL, 16, active count
- BPN_R, 128, right-black count
- LINES, 480, lines per frame
- TIMEOUT, 4096, cycles allowed in WAIT_REF
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock
- rst_n  in  1  reset
- s_valid  in  1  sensor beat valid
- s_ready  out  1  beat accepted when s_valid&s_ready
- s_sol  in  1  start-of-line marker on first beat
- s_data  in  DATA_WIDTH  pixel
- blk_valid  out  1  black pixel strobe to sorter
- act_valid  out  1  active pixel strobe to line buffer
- pix_data  out  DATA_WIDTH  registered pixel for either strobe
- ref_valid  in  1  sorter reference ready pulse
- m_ready  in  1  downstream can take a pixel
- rd_en  out  1  pop one corrected pixel
- rd_last  out  1  qualifies final rd_en
- line_done  out  1  one-cycle pulse
- frame_done  out  1  one-cycle pulse
- line_cnt  out  16  current line index
- err_timeout  out  1  sticky
- err_seq  out  1  sticky
- err_clr  in  1  clears sticky errors
REQ-003 Reset SHALL be rst_n, asynchronous, active-low; clock SHALL be clk.

Function
REQ-004 Line length L SHALL be BPS_L+BPN_L+READ_PIXEL+BPN_R; pixel counter pcnt SHALL be 16 bits, counting accepted beats from 0 at the s_sol beat.
REQ-005 FSM states SHALL be IDLE, PRE, BLK_L, ACT, BLK_R, WAIT_REF, READ.
REQ-006 s_ready SHALL be 1 in IDLE, PRE, BLK_L, ACT and BLK_R, and 0 in WAIT_REF and READ.
REQ-007 In IDLE, an accepted beat with s_sol=1 SHALL enter PRE (or BLK_L if BPS_L=0). An accepted beat with s_sol=0 SHALL be dropped and set err_seq.
REQ-008 Region transitions on accepted beats:
- pcnt in [BPS_L, BPS_L+BPN_L) -> BLK_L
- pcnt in [BPS_L+BPN_L, +READ_PIXEL) -> ACT
- pcnt in [BPS_R, L) -> BLK_R
- beat at pcnt=L-1 -> WAIT_REF
REQ-009 blk_valid and act_valid SHALL assert exactly one cycle after the accepted beat of their region, with pix_data = that beat's s_data. They SHALL never assert together. PRE beats SHALL produce no strobe.
REQ-010 An accepted s_sol=1 beat in any state other than IDLE SHALL set err_seq and restart the line with that beat as pcnt=0. line_done SHALL NOT pulse for the aborted line.
REQ-011 WAIT_REF: a timeout counter SHALL start at 0 on entry.
- ref_valid -> READ
- counter reaches TIMEOUT-1 with no ref_valid -> set err_timeout, return to IDLE, no line_done
- ref_valid and timeout in the same cycle -> ref_valid wins
REQ-012 ref_valid outside WAIT_REF SHALL be ignored and SHALL set err_seq.
REQ-013 READ: rd_en SHALL equal m_ready (combinational gate, registered state).
- exactly READ_PIXEL pops SHALL be issued
- rd_last SHALL be 1 on the final pop
- after the final pop: IDLE, and line_done pulses the next cycle
REQ-014 On line_done, line_cnt SHALL increment. At LINES-1 it SHALL wrap to 0 with frame_done pulsing in the same cycle as line_done.
REQ-015 err_clr SHALL clear both sticky errors. A simultaneous set SHALL take precedence over the clear.

Reset
REQ-016 On reset:
- state=IDLE; pcnt, timeout counter and line_cnt = 0
- all strobes, pulses and errors = 0
- pix_data = 0; s_ready = 1
REQ-017 Reset asserted mid-line SHALL discard the line immediately, with no line_done.

Structure
REQ-018 Package blc_pkg SHALL hold the FSM state enum and the L computation shared with the datapath.
REQ-019 One sub-module is natural: blc_rd_seq (READ pop counter, rd_last, line_done generation). All other logic SHALL be inline.
REQ-020 Elaboration SHALL fail if L > 65535 or READ_PIXEL = 0.

Verification
Bench parameters: BPS_L=1, BPN_L=4, READ_PIXEL=2, BPN_R=4, LINES=3, TIMEOUT=8, giving L=11.
REQ-021 Nominal line, data 0..10, s_valid held high:
- blk_valid for data 1-4 and 7-10; act_valid for 5-6
- s_ready drops after beat 10
- ref_valid then 2 pops, rd_last on the 2nd, line_done once, line_cnt=1
REQ-022 Three nominal lines -> frame_done coincides with the 3rd line_done, line_cnt=0.
REQ-023 No ref_valid -> err_timeout=1 after 8 WAIT_REF cycles, back to IDLE, s_ready=1, line_cnt unchanged.
REQ-024 s_sol reasserted at pcnt=6 -> err_seq=1, line restarts, next 10 beats complete a normal line.
REQ-025 m_ready toggled 1,0,0,1 in READ -> rd_en only on the high cycles, rd_last on the 2nd pop.
REQ-026 rst_n pulsed during ACT -> all outputs at reset values, no line_done; a fresh s_sol line then completes normally.

Source files
------------

// File: rtl/blc_pkg.sv
// Shared types and line-geometry helpers for the black-level line controller.
package blc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      BLK_L,
      ACT,
      BLK_R,
      WAIT_REF,
      READ
   } blc_state_e;

   // Total beats in one sensor line: pre-black, left black, active, right black.
   function automatic int blc_line_len(input int bps_l, input int bpn_l,
                                       input int read_pixel, input int bpn_r);
      return bps_l + bpn_l + read_pixel + bpn_r;
   endfunction

endpackage

// File: rtl/blc_rd_seq.sv
// Read-out sequencer: issues READ_PIXEL pops gated by m_ready and flags the line end.
module blc_rd_seq #(
   parameter int READ_PIXEL = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic m_ready,
   output logic rd_en,
   output logic rd_last,
   output logic line_done
);

   logic [15:0] pop_cnt;

   assign rd_en   = active & m_ready;
   assign rd_last = rd_en & (pop_cnt == 16'(READ_PIXEL - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_cnt   <= '0;
         line_done <= 1'b0;
      end else begin
         line_done <= rd_last;
         if (!active || rd_last) begin
            pop_cnt <= '0;
         end else if (rd_en) begin
            pop_cnt <= pop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/blc_line_ctrl.sv
// Sensor line controller: splits a line into black/active strobes, waits for the
// sorter reference, then drains the corrected active pixels.
module blc_line_ctrl import blc_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int BPS_L      = 1,
   parameter int BPN_L      = 128,
   parameter int READ_PIXEL = 16,
   parameter int BPN_R      = 128,
   parameter int LINES      = 480,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_sol,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  blk_valid,
   output logic                  act_valid,
   output logic [DATA_WIDTH-1:0] pix_data,
   input  logic                  ref_valid,
   input  logic                  m_ready,
   output logic                  rd_en,
   output logic                  rd_last,
   output logic                  line_done,
   output logic                  frame_done,
   output logic [15:0]           line_cnt,
   output logic                  err_timeout,
   output logic                  err_seq,
   input  logic                  err_clr
);

   localparam int L       = blc_line_len(BPS_L, BPN_L, READ_PIXEL, BPN_R);
   localparam int BPS_ACT = BPS_L + BPN_L;
   localparam int BPS_R   = BPS_ACT + READ_PIXEL;
   localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   generate
      if (L > 65535 || READ_PIXEL == 0) begin : g_bad_geometry
         $error("blc_line_ctrl: line length must fit 16 bits and READ_PIXEL must be nonzero");
      end
   endgenerate

   blc_state_e      state_q, state_d;
   logic [15:0]     pcnt_q, pcnt_d, bidx;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            accept, beat_ok, blk_d, act_d;
   logic            seq_set, to_set;
   logic            rd_active, rd_last_int;

   // The controller only refuses beats while the line is parked for reference/read-out.
   assign s_ready   = (state_q != WAIT_REF) && (state_q != READ);
   assign accept    = s_valid & s_ready;
   assign rd_active = (state_q == READ);
   assign rd_last   = rd_last_int;

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      tcnt_d  = tcnt_q;
      bidx    = pcnt_q + 16'd1;
      beat_ok = 1'b0;
      blk_d   = 1'b0;
      act_d   = 1'b0;
      seq_set = ref_valid && (state_q != WAIT_REF);
      to_set  = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (s_sol) begin
                  beat_ok = 1'b1;
                  bidx    = '0;
               end else begin
                  seq_set = 1'b1;
               end
            end
         end
         PRE, BLK_L, ACT, BLK_R: begin
            if (accept) begin
               beat_ok = 1'b1;
               if (s_sol) begin
                  seq_set = 1'b1;
                  bidx    = '0;
               end
            end
         end
         WAIT_REF: begin
            if (ref_valid) begin
               state_d = READ;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               to_set  = 1'b1;
               state_d = IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         READ: begin
            if (rd_last_int) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // State tracks the region of the most recently accepted beat.
      if (beat_ok) begin
         pcnt_d = bidx;
         tcnt_d = '0;
         if (bidx < 16'(BPS_L)) begin
            state_d = PRE;
         end else if (bidx < 16'(BPS_ACT)) begin
            state_d = BLK_L;
            blk_d   = 1'b1;
         end else if (bidx < 16'(BPS_R)) begin
            state_d = ACT;
            act_d   = 1'b1;
         end else begin
            state_d = BLK_R;
            blk_d   = 1'b1;
         end
         if (bidx == 16'(L - 1)) state_d = WAIT_REF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pcnt_q      <= '0;
         tcnt_q      <= '0;
         blk_valid   <= 1'b0;
         act_valid   <= 1'b0;
         pix_data    <= '0;
         line_cnt    <= '0;
         frame_done  <= 1'b0;
         err_seq     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         tcnt_q    <= tcnt_d;
         blk_valid <= blk_d;
         act_valid <= act_d;
         if (blk_d || act_d) pix_data <= s_data;

         // line_done is registered from the final pop, so line_cnt and frame_done move with it.
         frame_done <= rd_last_int && (line_cnt == 16'(LINES - 1));
         if (rd_last_int) begin
            line_cnt <= (line_cnt == 16'(LINES - 1)) ? 16'd0 : line_cnt + 16'd1;
         end

         if (seq_set)      err_seq <= 1'b1;
         else if (err_clr) err_seq <= 1'b0;
         if (to_set)       err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

   blc_rd_seq #(
      .READ_PIXEL(READ_PIXEL)
   ) u_rd_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .active   (rd_active),
      .m_ready  (m_ready),
      .rd_en    (rd_en),
      .rd_last  (rd_last_int),
      .line_done(line_done)
   );

endmodule

// File: tb/tb_blc_line_ctrl.sv
// Directed bench for blc_line_ctrl with a small line geometry (L = 11).
module tb_blc_line_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_sol = 1'b0;
   logic [7:0]  s_data = '0;
   logic        ref_valid = 1'b0;
   logic        m_ready = 1'b1;
   logic        err_clr = 1'b0;
   logic        s_ready, blk_valid, act_valid, rd_en, rd_last;
   logic        line_done, frame_done, err_timeout, err_seq;
   logic [7:0]  pix_data;
   logic [15:0] line_cnt;

   int checks = 0;
   int failures = 0;

   // Strobe history: newest byte in the low bits.
   logic [127:0] blk_vec = '0;
   logic [127:0] act_vec = '0;
   int blk_n = 0, act_n = 0, both_cnt = 0;
   int ld_cnt = 0, fd_cnt = 0, fd_alone = 0;
   int pop_cnt = 0, last_cnt = 0, last_pos = 0;

   always #5 clk = ~clk;

   blc_line_ctrl #(
      .DATA_WIDTH(8), .BPS_L(1), .BPN_L(4), .READ_PIXEL(2),
      .BPN_R(4), .LINES(3), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_sol(s_sol), .s_data(s_data), .blk_valid(blk_valid), .act_valid(act_valid),
      .pix_data(pix_data), .ref_valid(ref_valid), .m_ready(m_ready), .rd_en(rd_en),
      .rd_last(rd_last), .line_done(line_done), .frame_done(frame_done),
      .line_cnt(line_cnt), .err_timeout(err_timeout), .err_seq(err_seq), .err_clr(err_clr)
   );

   always @(negedge clk) begin
      if (blk_valid) begin blk_vec <= {blk_vec[119:0], pix_data}; blk_n <= blk_n + 1; end
      if (act_valid) begin act_vec <= {act_vec[119:0], pix_data}; act_n <= act_n + 1; end
      if (blk_valid && act_valid) both_cnt <= both_cnt + 1;
      if (line_done) ld_cnt <= ld_cnt + 1;
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (frame_done && !line_done) fd_alone <= fd_alone + 1;
      if (rd_en) pop_cnt <= pop_cnt + 1;
      if (rd_last) last_cnt <= last_cnt + 1;
      if (rd_last && rd_en) last_pos <= pop_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic beat(input logic [7:0] d, input logic sol);
      s_valid = 1'b1; s_data = d; s_sol = sol;
      @(posedge clk); #1;
      s_valid = 1'b0; s_sol = 1'b0;
   endtask

   task automatic send_beats(input logic [7:0] base, input int n, input logic sol_first);
      for (int i = 0; i < n; i++) beat(base + 8'(i), sol_first && (i == 0));
   endtask

   task automatic finish_line();
      ref_valid = 1'b1; tick(1); ref_valid = 1'b0;
      tick(6);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
   endtask

   task automatic test_reset();
      tick(2);
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
      checks++; if ({blk_valid, act_valid, line_done, frame_done, rd_en, rd_last} !== 6'b0) begin
         failures++; $display("FAIL rst_strobes got=%b exp=000000", {blk_valid, act_valid, line_done, frame_done, rd_en, rd_last}); end
      checks++; if (pix_data !== 8'h00) begin failures++; $display("FAIL rst_pix got=%h exp=00", pix_data); end
      checks++; if (line_cnt !== 16'd0) begin failures++; $display("FAIL rst_line_cnt got=%0d exp=0", line_cnt); end
      checks++; if ({err_seq, err_timeout} !== 2'b00) begin failures++; $display("FAIL rst_errs got=%b exp=00", {err_seq, err_timeout}); end
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_nominal();
      int b0, a0, l0, p0;
      b0 = blk_n; a0 = act_n; l0 = ld_cnt; p0 = pop_cnt;
      send_beats(8'h00, 10, 1'b1);
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL nom_ready_pre got=%b exp=1", s_ready); end
      beat(8'h0A, 1'b0);
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL nom_ready_drop got=%b exp=0", s_ready); end
      finish_line();
      checks++; if (blk_vec[63:0] !== 64'h01020304_0708090A || blk_n - b0 != 8) begin
         failures++; $display("FAIL nom_blk got=%h/%0d exp=010203040708090a/8", blk_vec[63:0], blk_n - b0); end
      checks++; if (act_vec[15:0] !== 16'h0506 || act_n - a0 != 2) begin
         failures++; $display("FAIL nom_act got=%h/%0d exp=0506/2", act_vec[15:0], act_n - a0); end
      checks++; if (pop_cnt - p0 != 2 || last_pos != p0 + 2) begin
         failures++; $display("FAIL nom_pops got=%0d last_at=%0d exp=2 last_at=%0d", pop_cnt - p0, last_pos, p0 + 2); end
      checks++; if (ld_cnt - l0 != 1) begin failures++; $display("FAIL nom_line_done got=%0d exp=1", ld_cnt - l0); end
      checks++; if (line_cnt !== 16'd1) begin failures++; $display("FAIL nom_line_cnt got=%0d exp=1", line_cnt); end
   endtask

   task automatic test_frame();
      send_beats(8'h00, 11, 1'b1); finish_line();
      checks++; if (line_cnt !== 16'd2 || fd_cnt != 0) begin
         failures++; $display("FAIL frame_line2 got=%0d fd=%0d exp=2 fd=0", line_cnt, fd_cnt); end
      send_beats(8'h00, 11, 1'b1); finish_line();
      checks++; if (fd_cnt != 1 || fd_alone != 0) begin
         failures++; $display("FAIL frame_done got=%0d alone=%0d exp=1 alone=0", fd_cnt, fd_alone); end
      checks++; if (line_cnt !== 16'd0) begin failures++; $display("FAIL frame_wrap got=%0d exp=0", line_cnt); end
   endtask

   task automatic test_idle_errors();
      int b0, a0;
      b0 = blk_n; a0 = act_n;
      pulse_clr();
      beat(8'h55, 1'b0);
      tick(1);
      checks++; if (err_seq !== 1'b1) begin failures++; $display("FAIL idle_drop_err got=%b exp=1", err_seq); end
      checks++; if (blk_n != b0 || act_n != a0) begin failures++; $display("FAIL idle_drop_strobe got=%0d exp=0", (blk_n - b0) + (act_n - a0)); end
      err_clr = 1'b1; ref_valid = 1'b1; tick(1); err_clr = 1'b0; ref_valid = 1'b0;
      checks++; if (err_seq !== 1'b1) begin failures++; $display("FAIL set_beats_clr got=%b exp=1", err_seq); end
      pulse_clr();
      checks++; if (err_seq !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", err_seq); end
   endtask

   task automatic test_timeout();
      int l0;
      l0 = ld_cnt;
      send_beats(8'h00, 11, 1'b1);
      tick(7);
      checks++; if (err_timeout !== 1'b0 || s_ready !== 1'b0) begin
         failures++; $display("FAIL to_early got=%b%b exp=00", err_timeout, s_ready); end
      tick(1);
      checks++; if (err_timeout !== 1'b1 || s_ready !== 1'b1) begin
         failures++; $display("FAIL to_fire got=%b%b exp=11", err_timeout, s_ready); end
      tick(3);
      checks++; if (ld_cnt != l0 || line_cnt !== 16'd0 || err_seq !== 1'b0) begin
         failures++; $display("FAIL to_after ld=%0d cnt=%0d seq=%b exp ld=0 cnt=0 seq=0", ld_cnt - l0, line_cnt, err_seq); end
      pulse_clr();
      checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_clr got=%b exp=0", err_timeout); end
   endtask

   task automatic test_ref_race();
      int l0, p0;
      l0 = ld_cnt; p0 = pop_cnt;
      send_beats(8'h00, 11, 1'b1);
      tick(7);
      ref_valid = 1'b1; tick(1); ref_valid = 1'b0;
      checks++; if (err_timeout !== 1'b0 || s_ready !== 1'b0) begin
         failures++; $display("FAIL race_ref_wins got=%b%b exp=00", err_timeout, s_ready); end
      tick(6);
      checks++; if (pop_cnt - p0 != 2 || ld_cnt - l0 != 1 || line_cnt !== 16'd1) begin
         failures++; $display("FAIL race_complete pops=%0d ld=%0d cnt=%0d exp 2 1 1", pop_cnt - p0, ld_cnt - l0, line_cnt); end
   endtask

   task automatic test_restart();
      int b0, a0, l0;
      b0 = blk_n; a0 = act_n; l0 = ld_cnt;
      send_beats(8'h00, 6, 1'b1);
      checks++; if (err_seq !== 1'b0) begin failures++; $display("FAIL rs_pre got=%b exp=0", err_seq); end
      send_beats(8'h20, 11, 1'b1);
      checks++; if (err_seq !== 1'b1) begin failures++; $display("FAIL rs_err got=%b exp=1", err_seq); end
      finish_line();
      checks++; if (blk_vec[95:0] !== 96'h01020304_21222324_2728292A || blk_n - b0 != 12) begin
         failures++; $display("FAIL rs_blk got=%h/%0d exp=01020304212223242728292a/12", blk_vec[95:0], blk_n - b0); end
      checks++; if (act_vec[23:0] !== 24'h052526 || act_n - a0 != 3) begin
         failures++; $display("FAIL rs_act got=%h/%0d exp=052526/3", act_vec[23:0], act_n - a0); end
      checks++; if (ld_cnt - l0 != 1 || line_cnt !== 16'd2) begin
         failures++; $display("FAIL rs_done ld=%0d cnt=%0d exp 1 2", ld_cnt - l0, line_cnt); end
      pulse_clr();
   endtask

   task automatic test_reset_mid();
      int l0, b0, a0;
      l0 = ld_cnt;
      send_beats(8'h00, 6, 1'b1);
      ref_valid = 1'b1; tick(1); ref_valid = 1'b0;
      checks++; if (err_seq !== 1'b1) begin failures++; $display("FAIL rm_pre_err got=%b exp=1", err_seq); end
      rst_n = 1'b0; #2;
      checks++; if ({s_ready, blk_valid, act_valid, rd_en, line_done, err_seq, err_timeout} !== 7'b1000000) begin
         failures++; $display("FAIL rm_outs got=%b exp=1000000", {s_ready, blk_valid, act_valid, rd_en, line_done, err_seq, err_timeout}); end
      checks++; if (pix_data !== 8'h00 || line_cnt !== 16'd0) begin
         failures++; $display("FAIL rm_regs pix=%h cnt=%0d exp 00 0", pix_data, line_cnt); end
      tick(2);
      rst_n = 1'b1;
      tick(2);
      checks++; if (ld_cnt != l0) begin failures++; $display("FAIL rm_no_done got=%0d exp=0", ld_cnt - l0); end
      b0 = blk_n; a0 = act_n;
      send_beats(8'h40, 11, 1'b1); finish_line();
      checks++; if (blk_vec[63:0] !== 64'h41424344_4748494A || blk_n - b0 != 8 || act_vec[15:0] !== 16'h4546 || act_n - a0 != 2) begin
         failures++; $display("FAIL rm_fresh blk=%h act=%h exp 414243444748494a 4546", blk_vec[63:0], act_vec[15:0]); end
      checks++; if (ld_cnt - l0 != 1 || line_cnt !== 16'd1) begin
         failures++; $display("FAIL rm_fresh_done ld=%0d cnt=%0d exp 1 1", ld_cnt - l0, line_cnt); end
   endtask

   task automatic test_mready();
      int p0;
      p0 = pop_cnt;
      m_ready = 1'b0;
      send_beats(8'h00, 11, 1'b1);
      ref_valid = 1'b1; tick(1); ref_valid = 1'b0;
      m_ready = 1'b1; @(negedge clk);
      checks++; if ({rd_en, rd_last} !== 2'b10) begin failures++; $display("FAIL mr_c1 got=%b exp=10", {rd_en, rd_last}); end
      @(posedge clk); #1 m_ready = 1'b0; @(negedge clk);
      checks++; if ({rd_en, rd_last} !== 2'b00) begin failures++; $display("FAIL mr_c2 got=%b exp=00", {rd_en, rd_last}); end
      @(posedge clk); #1; @(negedge clk);
      checks++; if ({rd_en, rd_last} !== 2'b00) begin failures++; $display("FAIL mr_c3 got=%b exp=00", {rd_en, rd_last}); end
      @(posedge clk); #1 m_ready = 1'b1; @(negedge clk);
      checks++; if ({rd_en, rd_last} !== 2'b11) begin failures++; $display("FAIL mr_c4 got=%b exp=11", {rd_en, rd_last}); end
      @(posedge clk); #1; @(negedge clk);
      checks++; if ({rd_en, line_done, frame_done} !== 3'b010) begin
         failures++; $display("FAIL mr_end got=%b exp=010", {rd_en, line_done, frame_done}); end
      tick(2);
      checks++; if (pop_cnt - p0 != 2 || last_cnt != ld_cnt || line_cnt !== 16'd2) begin
         failures++; $display("FAIL mr_totals pops=%0d last=%0d ld=%0d cnt=%0d exp pops=2 last=ld cnt=2", pop_cnt - p0, last_cnt, ld_cnt, line_cnt); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_frame();
      test_idle_errors();
      test_timeout();
      test_ref_race();
      test_restart();
      test_reset_mid();
      test_mready();
      checks++; if (both_cnt != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
